// File: rtl/router_pkg.sv
// rtl/router_pkg.sv - shared state type, LFSR constants and header packing for the router packet source
package router_pkg;

  typedef enum logic [1:0] {IDLE, HDR, PAY, PAR} state_e;

  // Galois feedback mask for x^16 + x^14 + x^13 + x^11 + 1
  localparam logic [15:0] LFSR_TAPS     = 16'hB400;
  localparam logic [15:0] LFSR_SEED_DEF = 16'hACE1;

  function automatic logic [15:0] lfsr_step(input logic [15:0] v);
    return {1'b0, v[15:1]} ^ (v[0] ? LFSR_TAPS : 16'h0000);
  endfunction

  function automatic logic [31:0] pack_hdr(input logic [31:0] len, input logic [31:0] addr,
                                           input int addr_w);
    return (len << addr_w) | addr;
  endfunction

endpackage

// File: rtl/router_pkt_src_if.sv
// rtl/router_pkt_src_if.sv - router ingress beat bus between packet source and router
interface router_pkt_src_if #(
  parameter int DATA_W = 8
);
  logic [DATA_W-1:0] data_out;
  logic              pkt_valid;
  logic              parity_slot;
  logic              busy;

  modport master (output data_out, output pkt_valid, output parity_slot, input busy);
  modport slave  (input data_out, input pkt_valid, input parity_slot, output busy);
endinterface

// File: rtl/router_lfsr.sv
// rtl/router_lfsr.sv - 16-bit Galois payload LFSR, reusable by the router checker
module router_lfsr
  import router_pkg::*;
#(
  parameter logic [15:0] SEED  = LFSR_SEED_DEF,
  parameter int          OUT_W = 8
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             en,
  output logic [OUT_W-1:0] value,
  output logic [OUT_W-1:0] value_nxt
);

  logic [15:0] lfsr_q, lfsr_d, lfsr_adv;

  always_comb begin
    lfsr_adv = lfsr_step(lfsr_q);
    lfsr_d   = en ? lfsr_adv : lfsr_q;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) lfsr_q <= SEED;
    else         lfsr_q <= lfsr_d;
  end

  assign value     = OUT_W'(lfsr_q);
  assign value_nxt = OUT_W'(lfsr_adv);

endmodule

// File: rtl/router_pkt_src.sv
// rtl/router_pkt_src.sv - router packet source: header, LFSR payload, XOR parity
// Optional PKT_SRC_ERR_INJECT_EN adds err_inj to invert the parity beat.
module router_pkt_src
  import router_pkg::*;
#(
  parameter int          DATA_W    = 8,
  parameter int          NUM_CH    = 3,
  parameter int          ADDR_W    = 2,
  parameter logic [15:0] LFSR_SEED = 16'hACE1,
  parameter int          CNT_W     = 16,
  localparam int         LEN_W     = DATA_W - ADDR_W
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              start,
  input  logic [ADDR_W-1:0] cfg_addr,
  input  logic [LEN_W-1:0]  cfg_len,
`ifdef PKT_SRC_ERR_INJECT_EN
  input  logic              err_inj,
`endif
  router_pkt_src_if.master  rif,
  output logic              active,
  output logic              done,
  output logic              cfg_err,
  output logic [CNT_W-1:0]  pkt_cnt
);

  state_e            state_q, state_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [DATA_W-1:0] par_q, par_d;
  logic              pkt_valid_q, pkt_valid_d;
  logic              parity_slot_q, parity_slot_d;
  logic              active_q, active_d;
  logic              done_q, done_d;
  logic              cfg_err_q, cfg_err_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [LEN_W-1:0]  beat_q, beat_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              inj_q, inj_d;

  logic              lfsr_en;
  logic [DATA_W-1:0] lfsr_val, lfsr_nxt;
  logic              xfer, addr_ok, launch, inj_in;
  logic [DATA_W-1:0] hdr, par_upd;

`ifdef PKT_SRC_ERR_INJECT_EN
  assign inj_in = err_inj;
`else
  assign inj_in = 1'b0;
`endif

  assign xfer    = !rif.busy;
  assign addr_ok = int'(cfg_addr) < NUM_CH;
  assign hdr     = DATA_W'(pack_hdr(32'(cfg_len), 32'(cfg_addr), ADDR_W));
  assign par_upd = par_q ^ data_q;

  router_lfsr #(
    .SEED  (LFSR_SEED),
    .OUT_W (DATA_W)
  ) u_lfsr (
    .clk       (clk),
    .resetn    (resetn),
    .en        (lfsr_en),
    .value     (lfsr_val),
    .value_nxt (lfsr_nxt)
  );

  always_comb begin
    state_d       = state_q;
    data_d        = data_q;
    par_d         = par_q;
    pkt_valid_d   = pkt_valid_q;
    parity_slot_d = parity_slot_q;
    active_d      = active_q;
    len_d         = len_q;
    beat_d        = beat_q;
    cnt_d         = cnt_q;
    inj_d         = inj_q;
    done_d        = 1'b0;
    cfg_err_d     = 1'b0;
    lfsr_en       = 1'b0;
    launch        = 1'b0;

    case (state_q)
      IDLE: launch = 1'b1;
      HDR: if (xfer) begin
        beat_d = '0;
        if (len_q != '0) begin
          state_d = PAY;
          data_d  = lfsr_val;
        end else begin
          state_d       = PAR;
          data_d        = inj_q ? ~par_q : par_q;
          pkt_valid_d   = 1'b0;
          parity_slot_d = 1'b1;
        end
      end
      PAY: if (xfer) begin
        lfsr_en = 1'b1;
        par_d   = par_upd;
        beat_d  = beat_q + 1'b1;
        if (beat_q == len_q - 1'b1) begin
          state_d       = PAR;
          data_d        = inj_q ? ~par_upd : par_upd;
          pkt_valid_d   = 1'b0;
          parity_slot_d = 1'b1;
        end else begin
          data_d = lfsr_nxt;
        end
      end
      PAR: if (xfer) begin
        state_d       = IDLE;
        data_d        = '0;
        parity_slot_d = 1'b0;
        active_d      = 1'b0;
        done_d        = 1'b1;
        cnt_d         = cnt_q + 1'b1;
        // the parity hand-off edge also samples start, so packets chain without a gap
        launch        = 1'b1;
      end
      default: state_d = IDLE;
    endcase

    if (launch && start) begin
      if (addr_ok) begin
        state_d       = HDR;
        data_d        = hdr;
        par_d         = hdr;
        pkt_valid_d   = 1'b1;
        parity_slot_d = 1'b0;
        active_d      = 1'b1;
        len_d         = cfg_len;
        inj_d         = inj_in;
      end else begin
        cfg_err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q       <= IDLE;
      data_q        <= '0;
      par_q         <= '0;
      pkt_valid_q   <= 1'b0;
      parity_slot_q <= 1'b0;
      active_q      <= 1'b0;
      done_q        <= 1'b0;
      cfg_err_q     <= 1'b0;
      len_q         <= '0;
      beat_q        <= '0;
      cnt_q         <= '0;
      inj_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      data_q        <= data_d;
      par_q         <= par_d;
      pkt_valid_q   <= pkt_valid_d;
      parity_slot_q <= parity_slot_d;
      active_q      <= active_d;
      done_q        <= done_d;
      cfg_err_q     <= cfg_err_d;
      len_q         <= len_d;
      beat_q        <= beat_d;
      cnt_q         <= cnt_d;
      inj_q         <= inj_d;
    end
  end

  assign rif.data_out    = data_q;
  assign rif.pkt_valid   = pkt_valid_q;
  assign rif.parity_slot = parity_slot_q;
  assign active          = active_q;
  assign done            = done_q;
  assign cfg_err         = cfg_err_q;
  assign pkt_cnt         = cnt_q;

endmodule

// File: tb/tb_router_pkt_src.sv
// tb/tb_router_pkt_src.sv - directed self-checking bench for router_pkt_src (8-bit, 3 channels)
module tb_router_pkt_src;

  logic        clk = 1'b0;
  logic        resetn;
  logic        start;
  logic [1:0]  cfg_addr;
  logic [5:0]  cfg_len;
`ifdef PKT_SRC_ERR_INJECT_EN
  logic        err_inj;
`endif
  logic        active, done, cfg_err;
  logic [15:0] pkt_cnt;

  int          n_checks = 0;
  int          n_errors = 0;
  logic [15:0] m_lfsr;
  int          m_cnt;
  logic [7:0]  beats[$];

  router_pkt_src_if #(.DATA_W(8)) rif ();

  router_pkt_src dut (
    .clk      (clk),
    .resetn   (resetn),
    .start    (start),
    .cfg_addr (cfg_addr),
    .cfg_len  (cfg_len),
`ifdef PKT_SRC_ERR_INJECT_EN
    .err_inj  (err_inj),
`endif
    .rif      (rif),
    .active   (active),
    .done     (done),
    .cfg_err  (cfg_err),
    .pkt_cnt  (pkt_cnt)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [15:0] m_step(input logic [15:0] v);
    return {1'b0, v[15:1]} ^ (v[0] ? 16'hB400 : 16'h0000);
  endfunction

  // Called at a negedge. launch=0 means the header is already on the bus (chained packet).
  task automatic run_pkt(input logic [1:0] a, input logic [5:0] l, input int stall_at,
                         input int stall_n, input bit inj, input bit launch, input bit mid_start,
                         input bit tail_en, input logic [1:0] ta, input logic [5:0] tl);
    logic [7:0] exp_b[$];
    logic [7:0] par;
    int         idx, stalls, cyc;
    bit         last;
    exp_b.push_back({l, a});
    par = {l, a};
    for (int i = 0; i < int'(l); i++) begin
      exp_b.push_back(m_lfsr[7:0]);
      par    = par ^ m_lfsr[7:0];
      m_lfsr = m_step(m_lfsr);
    end
    exp_b.push_back(inj ? ~par : par);
    beats.delete();
    if (launch) begin
      start    = 1'b1;
      cfg_addr = a;
      cfg_len  = l;
`ifdef PKT_SRC_ERR_INJECT_EN
      err_inj  = inj;
`endif
      @(negedge clk);
    end
    idx = 0; stalls = 0; cyc = 0;
    while (idx < exp_b.size()) begin
      last  = (idx == exp_b.size() - 1);
      start = 1'b0;
      check_eq("data_out", 32'(rif.data_out), 32'(exp_b[idx]));
      check_eq("pkt_valid", 32'(rif.pkt_valid), 32'(!last));
      check_eq("parity_slot", 32'(rif.parity_slot), 32'(last));
      check_eq("active", 32'(active), 32'd1);
      check_eq("done_in_pkt", 32'(done), 32'(!launch && cyc == 0));
      if (idx == stall_at && stalls < stall_n) begin
        rif.busy = 1'b1;
        stalls++;
      end else begin
        rif.busy = 1'b0;
        beats.push_back(rif.data_out);
        idx++;
        if (tail_en && last) begin
          start    = 1'b1;
          cfg_addr = ta;
          cfg_len  = tl;
        end
      end
      if (mid_start && idx == 3 && !last) begin
        start    = 1'b1;
        cfg_addr = 2'd0;
        cfg_len  = 6'd1;
      end
      cyc++;
      @(negedge clk);
    end
    start = 1'b0;
    m_cnt++;
    check_eq("done_pulse", 32'(done), 32'd1);
    check_eq("pkt_cnt", 32'(pkt_cnt), 32'(m_cnt));
    check_eq("active_after", 32'(active), 32'(tail_en));
    if (!tail_en) begin
      @(negedge clk);
      check_eq("done_one_cycle", 32'(done), 32'd0);
      check_eq("idle_data", 32'(rif.data_out), 32'd0);
      check_eq("idle_active", 32'(active), 32'd0);
    end
  endtask

  initial begin
    resetn   = 1'b0;
    start    = 1'b0;
    cfg_addr = '0;
    cfg_len  = '0;
    rif.busy = 1'b0;
`ifdef PKT_SRC_ERR_INJECT_EN
    err_inj  = 1'b0;
`endif
    m_lfsr = 16'hACE1;
    m_cnt  = 0;
    repeat (2) @(negedge clk);
    check_eq("rst_data", 32'(rif.data_out), 32'd0);
    check_eq("rst_valid", 32'(rif.pkt_valid), 32'd0);
    check_eq("rst_pslot", 32'(rif.parity_slot), 32'd0);
    check_eq("rst_active", 32'(active), 32'd0);
    check_eq("rst_done", 32'(done), 32'd0);
    check_eq("rst_cfg_err", 32'(cfg_err), 32'd0);
    check_eq("rst_pkt_cnt", 32'(pkt_cnt), 32'd0);
    resetn = 1'b1;
    @(negedge clk);

    // addr 0, len 14, no stall
    run_pkt(2'd0, 6'd14, -1, 0, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 6'd0);
    check_eq("t1_hdr", 32'(beats[0]), 32'h38);
    check_eq("t1_pay0", 32'(beats[1]), 32'hE1);
    check_eq("t1_pay1", 32'(beats[2]), 32'h70);
    check_eq("t1_pay2", 32'(beats[3]), 32'h38);
    check_eq("t1_beats", 32'(beats.size()), 32'd16);

    // addr 1, len 16, busy for 3 cycles on payload beat 5
    run_pkt(2'd1, 6'd16, 6, 3, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 6'd0);
    check_eq("t2_beats", 32'(beats.size()), 32'd18);

    // addr 2, len 0: header then parity equal to header
    run_pkt(2'd2, 6'd0, -1, 0, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 6'd0);
    check_eq("t3_hdr", 32'(beats[0]), 32'h02);
    check_eq("t3_par", 32'(beats[1]), 32'h02);

    // addr 3 is out of range for 3 channels
    start = 1'b1; cfg_addr = 2'd3; cfg_len = 6'd5;
    @(negedge clk);
    start = 1'b0;
    check_eq("t4_cfg_err", 32'(cfg_err), 32'd1);
    check_eq("t4_active", 32'(active), 32'd0);
    check_eq("t4_valid", 32'(rif.pkt_valid), 32'd0);
    @(negedge clk);
    check_eq("t4_cfg_err_pulse", 32'(cfg_err), 32'd0);
    check_eq("t4_active2", 32'(active), 32'd0);
    check_eq("t4_cnt", 32'(pkt_cnt), 32'(m_cnt));

    // mid-packet start ignored, then chained packet right after the parity beat
    run_pkt(2'd0, 6'd4, -1, 0, 1'b0, 1'b1, 1'b1, 1'b1, 2'd1, 6'd2);
    run_pkt(2'd1, 6'd2, -1, 0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 6'd0);
    check_eq("t5_hdr", 32'(beats[0]), 32'h09);

`ifdef PKT_SRC_ERR_INJECT_EN
    run_pkt(2'd1, 6'd3, -1, 0, 1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 6'd0);
    err_inj = 1'b0;
`endif

    // reset during payload aborts the packet and reseeds the LFSR
    start = 1'b1; cfg_addr = 2'd0; cfg_len = 6'd10;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("t6_mid_active", 32'(active), 32'd1);
    resetn = 1'b0;
    #1;
    check_eq("t6_rst_data", 32'(rif.data_out), 32'd0);
    check_eq("t6_rst_valid", 32'(rif.pkt_valid), 32'd0);
    check_eq("t6_rst_active", 32'(active), 32'd0);
    check_eq("t6_rst_cnt", 32'(pkt_cnt), 32'd0);
    @(negedge clk);
    check_eq("t6_no_done", 32'(done), 32'd0);
    resetn = 1'b1;
    m_lfsr = 16'hACE1;
    m_cnt  = 0;
    @(negedge clk);
    check_eq("t6_no_done2", 32'(done), 32'd0);
    run_pkt(2'd2, 6'd3, -1, 0, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 6'd0);
    check_eq("t6_pay0", 32'(beats[1]), 32'hE1);
    check_eq("t6_pay1", 32'(beats[2]), 32'h70);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, time %0t limit 200000", $time);
    $fatal(1);
  end

endmodule
